// File: rtl/xif_mem_responder_pkg.sv
// pa_xif_mem: shared types and helpers for the CORE-V-XIF memory responder.
//   state_e          - responder FSM states
//   TIMEOUT_DEFAULT  - default grant-to-rvalid cycle budget
//   size_to_bytes()  - log2 access size to byte count
//   is_misaligned()  - alignment / bus-width legality check
package pa_xif_mem;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_COMMIT,
    ST_REQ,
    ST_WAIT_R,
    ST_RESULT
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  function automatic int unsigned size_to_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

  // Only the low address byte matters: the largest encodable access is 128 bytes.
  function automatic logic is_misaligned(input logic [7:0]  addr_lo,
                                         input logic [2:0]  size,
                                         input int unsigned bus_bytes);
    int unsigned bytes;
    logic [7:0]  mask;
    bytes = size_to_bytes(size);
    mask  = 8'(bytes - 32'd1);
    return ((addr_lo & mask) != 8'h00) || (bytes > bus_bytes);
  endfunction

endpackage

// File: rtl/xif_mem_responder_commit_tracker.sv
// xif_commit_tracker: remembers the last commit record and whether the
// currently held transaction has been committed or killed.
//   ck, rst                 - clock, async active-low reset
//   commit_valid/id/kill    - commit interface from the core
//   accept, req_id          - new transaction being accepted and its id
//   held_id                 - id of the transaction currently held
//   committed, killed       - held id committed/killed, including this cycle's commit
//   killed_held             - registered kill flag (visible from the next cycle)
module xif_commit_tracker #(
  parameter int unsigned X_ID_WIDTH = 4
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  input  logic                  accept,
  input  logic [X_ID_WIDTH-1:0] req_id,
  input  logic [X_ID_WIDTH-1:0] held_id,
  output logic                  committed,
  output logic                  killed,
  output logic                  killed_held
);

  logic                  trk_valid_q, trk_valid_d;
  logic [X_ID_WIDTH-1:0] trk_id_q, trk_id_d;
  logic                  trk_kill_q, trk_kill_d;
  logic                  committed_q, committed_d;
  logic                  killed_q, killed_d;
  logic                  live_hit, acc_live_hit, trk_hit;

  assign live_hit     = commit_valid && (commit_id == held_id);
  assign acc_live_hit = commit_valid && (commit_id == req_id);
  assign trk_hit      = trk_valid_q && (trk_id_q == req_id);

  always_comb begin
    trk_valid_d = trk_valid_q;
    trk_id_d    = trk_id_q;
    trk_kill_d  = trk_kill_q;
    if (commit_valid) begin
      trk_valid_d = 1'b1;
      trk_id_d    = commit_id;
      trk_kill_d  = commit_kill;
    end
  end

  // On acceptance the flags restart from the stored record plus any commit
  // arriving in the same cycle; afterwards they only accumulate.
  always_comb begin
    if (accept) begin
      committed_d = (trk_hit && !trk_kill_q) || (acc_live_hit && !commit_kill);
      killed_d    = (trk_hit && trk_kill_q)  || (acc_live_hit && commit_kill);
    end else begin
      committed_d = committed_q || (live_hit && !commit_kill);
      killed_d    = killed_q    || (live_hit && commit_kill);
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      trk_valid_q <= 1'b0;
      trk_id_q    <= '0;
      trk_kill_q  <= 1'b0;
      committed_q <= 1'b0;
      killed_q    <= 1'b0;
    end else begin
      trk_valid_q <= trk_valid_d;
      trk_id_q    <= trk_id_d;
      trk_kill_q  <= trk_kill_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
    end
  end

  assign committed   = committed_q || (live_hit && !commit_kill);
  assign killed      = killed_q    || (live_hit && commit_kill);
  assign killed_held = killed_q;

endmodule

// File: rtl/xif_mem_responder.sv
// xif_mem_responder: core-side responder for CORE-V-XIF mem / mem_result.
// Accepts one coprocessor memory transaction at a time, checks alignment,
// holds speculative stores until commit, runs the access on a grant/rvalid
// data bus and returns one mem_result per non-killed transaction.
//   mem_*         - coprocessor request channel (mem_ready = idle)
//   commit_*      - commit/kill strobe from the core
//   mem_result_*  - single-cycle result strobe, fields hold between results
//   dmem_*        - core data-memory port (req/gnt, rvalid/rdata/err)
module xif_mem_responder
  import pa_xif_mem::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned FLEN           = 32,
  parameter int unsigned X_ID_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [X_ID_WIDTH-1:0] mem_req_id,
  input  logic [XLEN-1:0]       mem_req_addr,
  input  logic [FLEN-1:0]       mem_req_wdata,
  input  logic [FLEN/8-1:0]     mem_req_be,
  input  logic [2:0]            mem_req_size,
  input  logic                  mem_req_we,
  input  logic                  mem_req_spec,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output logic                  mem_result_valid,
  output logic [X_ID_WIDTH-1:0] mem_result_id,
  output logic [FLEN-1:0]       mem_result_rdata,
  output logic                  mem_result_err,
  output logic                  mem_result_dbg,
  output logic                  dmem_req,
  input  logic                  dmem_gnt,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [FLEN/8-1:0]     dmem_be,
  output logic [FLEN-1:0]       dmem_wdata,
  input  logic                  dmem_rvalid,
  input  logic [FLEN-1:0]       dmem_rdata,
  input  logic                  dmem_err
);

  localparam int unsigned BEW = FLEN / 8;
  localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [X_ID_WIDTH-1:0] id_q, id_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [FLEN-1:0]       wdata_q, wdata_d;
  logic [BEW-1:0]        be_q, be_d;
  logic [2:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  spec_q, spec_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;
  logic [FLEN-1:0]       res_rdata_q, res_rdata_d;
  logic                  res_err_q, res_err_d;

  logic accept, misaligned, timeout;
  logic committed, killed, killed_held;

  assign accept     = mem_valid && (state_q == ST_IDLE);
  assign misaligned = is_misaligned(addr_q[7:0], size_q, BEW);
  assign timeout    = (cnt_q == CNT_LAST);

  xif_commit_tracker #(
    .X_ID_WIDTH (X_ID_WIDTH)
  ) u_tracker (
    .ck           (ck),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_kill  (commit_kill),
    .accept       (accept),
    .req_id       (mem_req_id),
    .held_id      (id_q),
    .committed    (committed),
    .killed       (killed),
    .killed_held  (killed_held)
  );

  // State register
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (mem_valid) state_d = ST_CHECK;
      ST_CHECK: begin
        if (killed)                            state_d = ST_IDLE;
        else if (misaligned)                   state_d = ST_RESULT;
        else if (we_q && spec_q && !committed) state_d = ST_WAIT_COMMIT;
        else                                   state_d = ST_REQ;
      end
      ST_WAIT_COMMIT: begin
        if (killed)         state_d = ST_IDLE;
        else if (committed) state_d = ST_REQ;
      end
      ST_REQ:    if (dmem_gnt) state_d = ST_WAIT_R;
      ST_WAIT_R: if (dmem_rvalid || timeout) state_d = ST_RESULT;
      ST_RESULT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs; a kill seen after CHECK still lets the access finish but hides the result
  always_comb begin
    mem_ready        = (state_q == ST_IDLE);
    dmem_req         = (state_q == ST_REQ);
    mem_result_valid = (state_q == ST_RESULT) && !killed_held;
  end

  // Request capture, timeout counter and result fields
  always_comb begin
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    size_d      = size_q;
    we_d        = we_q;
    spec_d      = spec_q;
    cnt_d       = cnt_q;
    res_id_d    = res_id_q;
    res_rdata_d = res_rdata_q;
    res_err_d   = res_err_q;
    if (accept) begin
      id_d    = mem_req_id;
      addr_d  = mem_req_addr;
      wdata_d = mem_req_wdata;
      be_d    = mem_req_be;
      size_d  = mem_req_size;
      we_d    = mem_req_we;
      spec_d  = mem_req_spec;
    end
    unique case (state_q)
      ST_CHECK: begin
        if (!killed && misaligned) begin
          res_id_d    = id_q;
          res_rdata_d = '0;
          res_err_d   = 1'b1;
        end
      end
      ST_REQ: if (dmem_gnt) cnt_d = '0;
      ST_WAIT_R: begin
        if (dmem_rvalid) begin
          res_id_d    = id_q;
          res_rdata_d = we_q ? '0 : dmem_rdata;
          res_err_d   = dmem_err;
        end else if (timeout) begin
          res_id_d    = id_q;
          res_rdata_d = '0;
          res_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      spec_q      <= 1'b0;
      cnt_q       <= '0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      size_q      <= size_d;
      we_q        <= we_d;
      spec_q      <= spec_d;
      cnt_q       <= cnt_d;
      res_id_q    <= res_id_d;
      res_rdata_q <= res_rdata_d;
      res_err_q   <= res_err_d;
    end
  end

  assign mem_result_id    = res_id_q;
  assign mem_result_rdata = res_rdata_q;
  assign mem_result_err   = res_err_q;
  assign mem_result_dbg   = 1'b0;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_be          = be_q;
  assign dmem_wdata       = wdata_q;

endmodule

// File: doc/xif_mem_responder.md
Name: xif_mem_responder

Overview:
- Core-side responder for the CORE-V-XIF memory request/response and memory result interfaces.
- Accepts one coprocessor memory transaction at a time (e.g. FLW/FSW from rvfpm) and checks alignment.
- Holds speculative stores until commit, performs the access on a simple grant/rvalid data bus, and returns exactly one mem_result per non-killed transaction.
- Sits between the coprocessor's mem_* ports and the core's data-memory port.

Parameters:
- XLEN, 32, address width
- FLEN, 32, data width of wdata/rdata; must be 32 or 64
- X_ID_WIDTH, 4, instruction id width
- TIMEOUT_CYCLES, 16, maximum cycles from dmem grant to rvalid before an error result; minimum 2

Ports:
- ck  input  1  clock
- rst  input  1  asynchronous, active-low reset
- mem_valid  input  1  coprocessor request valid
- mem_ready  output  1  responder can accept a request
- mem_req_id  input  X_ID_WIDTH  instruction id
- mem_req_addr  input  XLEN  byte address
- mem_req_wdata  input  FLEN  store data
- mem_req_be  input  FLEN/8  byte enables
- mem_req_size  input  3  log2 of access bytes
- mem_req_we  input  1  1 = store
- mem_req_spec  input  1  request is speculative
- commit_valid  input  1  commit strobe
- commit_id  input  X_ID_WIDTH  committed or killed id
- commit_kill  input  1  kill the instruction
- mem_result_valid  output  1  result strobe, single cycle, no backpressure
- mem_result_id  output  X_ID_WIDTH  id of the result
- mem_result_rdata  output  FLEN  load data; 0 for stores
- mem_result_err  output  1  misalignment, bus error or timeout
- mem_result_dbg  output  1  tied 0
- dmem_req  output  1  data bus request
- dmem_gnt  input  1  bus grant
- dmem_we  output  1  bus write enable
- dmem_addr  output  XLEN  bus address
- dmem_be  output  FLEN/8  bus byte enables
- dmem_wdata  output  FLEN  bus write data
- dmem_rvalid  input  1  bus response valid
- dmem_rdata  input  FLEN  bus read data
- dmem_err  input  1  bus error; qualified by dmem_rvalid

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0 except mem_ready = 1; request registers cleared; commit tracker invalid.
- mem_ready = (state == IDLE). A transaction is accepted on the posedge where mem_valid && mem_ready; all mem_req_* fields are registered at that edge.
- Commit tracker: on every commit_valid, register {commit_id, commit_kill, valid}. A held request counts as committed or killed when:
  - the tracker matches its id at acceptance, or
  - a commit for its id arrives in any later cycle, including the acceptance cycle itself.
- FSM states and transitions:
  - IDLE -> CHECK on accept.
  - CHECK, one cycle:
    - misaligned (addr mod 2^size != 0) or 2^size > FLEN/8 -> RESULT with err = 1 and no bus access;
    - store && spec && not yet committed -> WAIT_COMMIT;
    - otherwise -> REQ.
  - WAIT_COMMIT: matching commit with kill = 1 -> IDLE, no result ever; matching commit with kill = 0 -> REQ.
  - REQ: dmem_req = 1, driving the held addr/be/wdata/we. dmem_gnt -> WAIT_R and clear the timeout counter.
  - WAIT_R: dmem_rvalid -> RESULT, capturing rdata (forced to 0 when we = 1) and err = dmem_err. Counter reaching TIMEOUT_CYCLES -> RESULT with err = 1 and rdata = 0; a late rvalid is ignored.
  - RESULT: mem_result_valid = 1 for exactly one cycle -> IDLE.
- Loads are never held for commit. A kill arriving while a load is in REQ or WAIT_R lets the access complete but suppresses the result (RESULT -> IDLE with valid held 0).
- A kill for the held id arriving in CHECK also aborts the transaction: -> IDLE, no result.
- Best-case latency with gnt in REQ and rvalid in the first WAIT_R cycle: acceptance edge T, mem_result_valid high in cycle T+4.
- mem_result_* fields hold their last values outside RESULT; only valid qualifies them.
- Reset asserted mid-transaction drops the transaction immediately: no result and dmem_req low.

Decomposition:
- Package pa_xif_mem: FSM state enum, size-to-bytes function, alignment-check function, default TIMEOUT constant.
- Sub-module xif_commit_tracker: holds the last commit record plus per-held-id committed/killed flags.
- Everything else lives in a single module.

Test Plan:
- Load addr 0x100, size 2, spec 1; gnt immediate, rvalid next cycle with rdata 0x3F800000 -> result id 3, rdata 0x3F800000, err 0, valid exactly 4 cycles after accept, mem_ready low in between.
- Store addr 0x104, wdata 0x40490FDB, spec 1; commit id 5 kill 0 after 6 cycles -> dmem_req asserted only after the commit; result rdata 0, err 0.
- Speculative store id 7 followed by commit id 7 kill 1 -> no dmem_req, no mem_result; mem_ready returns high.
- Misaligned load addr 0x102, size 2 -> mem_result err 1 in cycle T+2 with no dmem_req; size 3 with FLEN = 32 -> err 1.
- Grant given but rvalid withheld for 20 cycles, TIMEOUT_CYCLES = 16 -> err 1 result after 16 cycles; the later rvalid produces no second result.
- rst pulsed low while in WAIT_R -> outputs reset immediately; the next request is processed normally.
